// File: rtl/mpmc10_cache_ctrl.sv
// mpmc10 read-cache write-side sequencer: fill / write-through update / invalidate.
// Optional MPMC10_CACHE_CTRL_STATS_EN adds 32-bit event counters.
module mpmc10_cache_ctrl #(
    parameter int CACHE_ASSOC = 4,
    parameter int SETS        = 128,
    parameter int LINE_W      = 256,
    parameter int TAG_W       = 19
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic [31:0]       fill_adr,
    input  logic [LINE_W-1:0] fill_dat,
    output logic              fill_ack,
    input  logic              upd_req,
    input  logic [31:0]       upd_adr,
    input  logic [31:0]       upd_sel,
    input  logic [LINE_W-1:0] upd_dat,
    output logic              upd_ack,
    output logic              upd_hit,
    input  logic              inv_req,
    input  logic [31:0]       inv_adr,
    output logic              inv_ack,
    output logic [31:0]       wr,
    output logic [2:0]        wway,
    output logic [31:0]       wadr,
    output logic [LINE_W-1:0] wdat,
    output logic [TAG_W-1:0]  wtag,
    output logic              inv,
    output logic              busy
`ifdef MPMC10_CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_fill,
    output logic [31:0]       stat_evict,
    output logic [31:0]       stat_inv_hit,
    output logic [31:0]       stat_upd_hit
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (CACHE_ASSOC > 1) ? $clog2(CACHE_ASSOC) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, LOOKUP, WRITE} state_t;
    typedef enum logic [1:0] {REQ_FILL, REQ_UPD, REQ_INV} req_t;

    state_t state, nxt;
    req_t   rq_type;
    logic [IDX_W-1:0]  set_cnt;
    logic [31:0]       rq_adr;
    logic [31:0]       rq_sel;
    logic [LINE_W-1:0] rq_dat;

    logic [CACHE_ASSOC-1:0] valid   [SETS];
    logic [TAG_W-1:0]       tag_mem [SETS][CACHE_ASSOC];
    logic [WAY_W-1:0]       victim  [SETS];

    logic [IDX_W-1:0] rq_idx;
    logic [TAG_W-1:0] rq_tag;
    logic             hit, free, evict;
    logic [WAY_W-1:0] hit_way, free_way, tgt;

    assign rq_idx = rq_adr[6 +: IDX_W];
    assign rq_tag = rq_adr[31 -: TAG_W];
    assign busy   = (state != IDLE);

    always_ff @(posedge wclk) begin
        if (rst) begin
            state   <= CLEAR;
            set_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == CLEAR)
                set_cnt <= set_cnt + IDX_W'(1);
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            CLEAR:   if (set_cnt == IDX_W'(SETS - 1)) nxt = IDLE;
            IDLE:    if (inv_req || fill_req || upd_req) nxt = LOOKUP;
            LOOKUP:  nxt = WRITE;
            WRITE:   nxt = IDLE;
            default: nxt = CLEAR;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (state == IDLE) begin
            if (inv_req) begin
                rq_type <= REQ_INV;
                rq_adr  <= inv_adr;
            end else if (fill_req) begin
                rq_type <= REQ_FILL;
                rq_adr  <= fill_adr;
                rq_dat  <= fill_dat;
            end else if (upd_req) begin
                rq_type <= REQ_UPD;
                rq_adr  <= upd_adr;
                rq_sel  <= upd_sel;
                rq_dat  <= upd_dat;
            end
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int unsigned w = 0; w < CACHE_ASSOC; w++) begin
            if (!hit && valid[rq_idx][WAY_W'(w)] && tag_mem[rq_idx][w] == rq_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!free && !valid[rq_idx][WAY_W'(w)]) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        evict = (rq_type == REQ_FILL) && !hit && !free;
        tgt   = hit ? hit_way : (free ? free_way : victim[rq_idx]);
    end

    // Shadow commits on the LOOKUP->WRITE edge; the next LOOKUP is at least two
    // cycles later, so it always sees the post-WRITE state.
    always_ff @(posedge wclk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                valid[set_cnt]  <= '0;
                victim[set_cnt] <= '0;
            end else if (state == LOOKUP) begin
                if (rq_type == REQ_FILL) begin
                    valid[rq_idx][tgt]   <= 1'b1;
                    tag_mem[rq_idx][tgt] <= rq_tag;
                    if (evict)
                        victim[rq_idx] <= (victim[rq_idx] == WAY_W'(CACHE_ASSOC - 1)) ?
                                          '0 : victim[rq_idx] + WAY_W'(1);
                end else if (rq_type == REQ_INV && hit) begin
                    valid[rq_idx][hit_way] <= 1'b0;
                end
            end
        end
    end

    // Cache outputs are registered so they are valid exactly during WRITE.
    always_ff @(posedge wclk) begin
        if (rst) begin
            wr       <= '0;
            inv      <= 1'b0;
            fill_ack <= 1'b0;
            upd_ack  <= 1'b0;
            inv_ack  <= 1'b0;
            upd_hit  <= 1'b0;
            wway     <= '0;
            wadr     <= '0;
            wdat     <= '0;
            wtag     <= '0;
        end else begin
            wr       <= '0;
            inv      <= 1'b0;
            fill_ack <= 1'b0;
            upd_ack  <= 1'b0;
            inv_ack  <= 1'b0;
            if (state == LOOKUP) begin
                case (rq_type)
                    REQ_FILL: begin
                        fill_ack <= 1'b1;
                        wr       <= '1;
                        wway     <= 3'(tgt);
                        wadr     <= rq_adr;
                        wdat     <= rq_dat;
                        wtag     <= rq_tag;
                    end
                    REQ_UPD: begin
                        upd_ack <= 1'b1;
                        upd_hit <= hit;
                        wadr    <= rq_adr;
                        if (hit) begin
                            wr   <= rq_sel;
                            wway <= 3'(hit_way);
                            wdat <= rq_dat;
                            wtag <= rq_tag;
                        end
                    end
                    default: begin
                        inv_ack <= 1'b1;
                        if (hit) begin
                            inv  <= 1'b1;
                            wway <= 3'(hit_way);
                            wadr <= rq_adr;
                        end
                    end
                endcase
            end
        end
    end

`ifdef MPMC10_CACHE_CTRL_STATS_EN
    always_ff @(posedge wclk) begin
        if (rst) begin
            stat_fill    <= '0;
            stat_evict   <= '0;
            stat_inv_hit <= '0;
            stat_upd_hit <= '0;
        end else if (state == LOOKUP) begin
            if (rq_type == REQ_FILL) stat_fill <= stat_fill + 32'd1;
            if (evict) stat_evict <= stat_evict + 32'd1;
            if (rq_type == REQ_INV && hit) stat_inv_hit <= stat_inv_hit + 32'd1;
            if (rq_type == REQ_UPD && hit) stat_upd_hit <= stat_upd_hit + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mpmc10_cache_ctrl.sv
// Directed self-checking bench for mpmc10_cache_ctrl (default build, ASSOC=4).
module tb_mpmc10_cache_ctrl;

    localparam int K_FILL = 0;
    localparam int K_UPD  = 1;
    localparam int K_INV  = 2;

    logic         wclk = 1'b0;
    logic         rst;
    logic         fill_req, upd_req, inv_req;
    logic [31:0]  fill_adr, upd_adr, upd_sel, inv_adr;
    logic [255:0] fill_dat, upd_dat;
    logic         fill_ack, upd_ack, upd_hit, inv_ack, inv, busy;
    logic [31:0]  wr, wadr;
    logic [2:0]   wway;
    logic [255:0] wdat;
    logic [18:0]  wtag;

    int n_chk = 0;
    int n_err = 0;
    int lat;
    int bad;
    logic [31:0]  o_wr, o_wadr;
    logic [2:0]   o_way;
    logic [18:0]  o_tag;
    logic [255:0] o_dat;
    logic         o_inv, o_hit;

    mpmc10_cache_ctrl #(.CACHE_ASSOC(4), .SETS(128), .LINE_W(256), .TAG_W(19)) dut (
        .wclk(wclk), .rst(rst),
        .fill_req(fill_req), .fill_adr(fill_adr), .fill_dat(fill_dat), .fill_ack(fill_ack),
        .upd_req(upd_req), .upd_adr(upd_adr), .upd_sel(upd_sel), .upd_dat(upd_dat),
        .upd_ack(upd_ack), .upd_hit(upd_hit),
        .inv_req(inv_req), .inv_adr(inv_adr), .inv_ack(inv_ack),
        .wr(wr), .wway(wway), .wadr(wadr), .wdat(wdat), .wtag(wtag), .inv(inv), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic start(input int kind, input logic [31:0] adr, input logic [255:0] dat,
                         input logic [31:0] sel);
        case (kind)
            K_FILL: begin fill_req = 1'b1; fill_adr = adr; fill_dat = dat; end
            K_UPD:  begin upd_req = 1'b1; upd_adr = adr; upd_dat = dat; upd_sel = sel; end
            default: begin inv_req = 1'b1; inv_adr = adr; end
        endcase
    endtask

    task automatic wait_ack(input int kind);
        logic got;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            lat++;
            if ((kind == K_FILL && fill_ack) || (kind == K_UPD && upd_ack) ||
                (kind == K_INV && inv_ack)) begin
                got = 1'b1;
                o_wr = wr; o_way = wway; o_tag = wtag; o_wadr = wadr;
                o_dat = wdat; o_inv = inv; o_hit = upd_hit;
            end
        end
        if (!got) chk("ack_timeout", 1'b0, 1'b1);
        case (kind)
            K_FILL:  fill_req = 1'b0;
            K_UPD:   upd_req = 1'b0;
            default: inv_req = 1'b0;
        endcase
        tick();
    endtask

    task automatic req(input int kind, input logic [31:0] adr, input logic [255:0] dat,
                       input logic [31:0] sel);
        start(kind, adr, dat, sel);
        wait_ack(kind);
    endtask

    // Holds fill_req through CLEAR and counts cycles where busy drops or a write leaks.
    task automatic through_clear();
        bad = 0;
        for (int i = 0; i < 127; i++) begin
            tick();
            if (!busy || fill_ack || wr != 32'd0) bad++;
        end
        chk("clear_busy", 32'(bad), 32'd0);
        tick();
        chk("clear_done_idle", busy, 1'b0);
    endtask

    logic [255:0] d1, d2, du;

    initial begin
        d1 = {8{32'h1111_2222}};
        d2 = {8{32'h3333_4444}};
        du = {8{32'hA5A5_5A5A}};
        rst = 1'b1;
        fill_req = 1'b0; upd_req = 1'b0; inv_req = 1'b0;
        fill_adr = '0; upd_adr = '0; upd_sel = '0; inv_adr = '0;
        fill_dat = '0; upd_dat = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wr", wr, 32'd0);
        chk("rst_inv", inv, 1'b0);
        chk("rst_acks", {fill_ack, upd_ack, inv_ack}, 3'b000);
        chk("rst_wway", wway, 3'd0);
        chk("rst_wadr", wadr, 32'd0);
        chk("rst_wdat", wdat, 256'd0);
        chk("rst_wtag", wtag, 19'd0);
        chk("rst_busy", busy, 1'b1);

        // first fill raised during CLEAR: served 2 edges after CLEAR ends
        start(K_FILL, 32'h0000_2040, d1, 32'd0);
        through_clear();
        tick();
        chk("lookup_busy", busy, 1'b1);
        chk("lookup_noack", fill_ack, 1'b0);
        tick();
        chk("f1_ack", fill_ack, 1'b1);
        chk("f1_wr", wr, 32'hFFFF_FFFF);
        chk("f1_way", wway, 3'd0);
        chk("f1_tag", wtag, 19'd1);
        chk("f1_wadr", wadr, 32'h0000_2040);
        chk("f1_wdat", wdat, d1);
        fill_req = 1'b0;
        tick();
        chk("f1_ack_pulse", fill_ack, 1'b0);
        chk("f1_wr_pulse", wr, 32'd0);
        chk("f1_wadr_hold", wadr, 32'h0000_2040);

        req(K_FILL, 32'h0000_4040, d2, 32'd0);
        chk("f2_lat", 32'(lat), 32'd2);
        chk("f2_way", o_way, 3'd1);
        chk("f2_tag", o_tag, 19'd2);
        chk("f2_wr", o_wr, 32'hFFFF_FFFF);

        req(K_UPD, 32'h0000_2040, du, 32'h0000_000F);
        chk("u1_wr", o_wr, 32'h0000_000F);
        chk("u1_way", o_way, 3'd0);
        chk("u1_hit", o_hit, 1'b1);
        chk("u1_tag", o_tag, 19'd1);
        chk("u1_wdat", o_dat, du);

        req(K_UPD, 32'h0000_8040, du, 32'h0000_000F);
        chk("u2_wr", o_wr, 32'd0);
        chk("u2_hit", o_hit, 1'b0);

        req(K_UPD, 32'h0000_4040, du, 32'd0);
        chk("u3_hit", o_hit, 1'b1);
        chk("u3_wr", o_wr, 32'd0);
        chk("u3_way", o_way, 3'd1);

        // inv wins over fill; the fill then lands in the freed way 0
        start(K_INV, 32'h0000_2040, '0, 32'd0);
        start(K_FILL, 32'h0000_2040, d1, 32'd0);
        wait_ack(K_INV);
        chk("i1_inv", o_inv, 1'b1);
        chk("i1_way", o_way, 3'd0);
        chk("i1_wr", o_wr, 32'd0);
        chk("i1_wadr", o_wadr, 32'h0000_2040);
        chk("i1_fill_pending", fill_ack, 1'b0);
        wait_ack(K_FILL);
        chk("f3_way", o_way, 3'd0);
        chk("f3_inv", o_inv, 1'b0);

        req(K_FILL, 32'h0000_6040, d2, 32'd0);
        chk("f4_way", o_way, 3'd2);
        req(K_FILL, 32'h0000_8040, d2, 32'd0);
        chk("f5_way", o_way, 3'd3);
        req(K_FILL, 32'h0000_A040, d2, 32'd0);
        chk("f6_evict_way", o_way, 3'd0);
        req(K_FILL, 32'h0000_C040, d2, 32'd0);
        chk("f7_evict_way", o_way, 3'd1);
        req(K_FILL, 32'h0000_C040, d1, 32'd0);
        chk("f8_hit_way", o_way, 3'd1);
        req(K_FILL, 32'h0000_E040, d1, 32'd0);
        chk("f9_victim_way", o_way, 3'd2);
        chk("f9_tag", o_tag, 19'd7);

        req(K_INV, 32'h0000_2040, '0, 32'd0);
        chk("i2_miss_inv", o_inv, 1'b0);
        req(K_INV, 32'h0000_A040, '0, 32'd0);
        chk("i3_inv", o_inv, 1'b1);
        chk("i3_way", o_way, 3'd0);
        req(K_UPD, 32'h0000_A040, du, 32'hFFFF_FFFF);
        chk("u4_after_inv_hit", o_hit, 1'b0);
        chk("u4_after_inv_wr", o_wr, 32'd0);

        req(K_FILL, 32'h0000_2080, d1, 32'd0);
        chk("s2_way", o_way, 3'd0);
        chk("s2_tag", o_tag, 19'd1);

        // reset while a fill is in LOOKUP aborts it and reruns CLEAR
        start(K_FILL, 32'h0000_4080, d2, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_abort_ack", fill_ack, 1'b0);
        chk("rst_abort_wr", wr, 32'd0);
        chk("rst_abort_busy", busy, 1'b1);
        through_clear();
        wait_ack(K_FILL);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_way", o_way, 3'd0);
        chk("post_rst_tag", o_tag, 19'd2);
        req(K_FILL, 32'h0000_2080, d1, 32'd0);
        chk("post_rst_cleared_way", o_way, 3'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
